vx_warp_rr_sched: RTL and testbench



---
 rtl/vx_warp_rr_sched.sv | 184 ++++++++++++++++++
 tb/tb_vx_warp_rr_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_warp_rr_sched.sv
// vx_warp_rr_sched: per-core round-robin warp scheduler feeding the fetch stage.
// Tracks per-warp active/stalled/tmask/PC and presents one eligible warp per
// cycle through a registered valid/ready output slot.
// Optional build macro: VX_SCHED_PERF_EN enables the 64-bit saturating
// perf_idles / perf_stalls counters; without it both outputs are tied to zero.
module vx_warp_rr_sched #(
  parameter int NUM_WARPS  = 4,
  parameter int THREAD_CNT = 4,
  parameter int XLEN       = 32,
  parameter int UUID_WIDTH = 44,
  parameter logic [XLEN-1:0] STARTUP_ADDR = 32'h80000000,
  parameter int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  spawn_valid,
  input  logic [NUM_WARPS-1:0]  spawn_mask,
  input  logic [XLEN-1:0]       spawn_pc,

  input  logic                  unlock_valid,
  input  logic [NW_WIDTH-1:0]   unlock_wid,

  input  logic                  ctl_valid,
  input  logic [NW_WIDTH-1:0]   ctl_wid,
  input  logic [THREAD_CNT-1:0] ctl_tmask,
  input  logic [XLEN-1:0]       ctl_pc,

  output logic                  sched_valid,
  output logic [UUID_WIDTH-1:0] sched_uuid,
  output logic [NW_WIDTH-1:0]   sched_wid,
  output logic [THREAD_CNT-1:0] sched_tmask,
  output logic [XLEN-1:0]       sched_pc,
  input  logic                  sched_ready,

  output logic                  busy,
  output logic [63:0]           perf_idles,
  output logic [63:0]           perf_stalls
);

  // Per-warp state
  logic [NUM_WARPS-1:0]  active;
  logic [NUM_WARPS-1:0]  stalled;
  logic [THREAD_CNT-1:0] tmask [NUM_WARPS];
  logic [XLEN-1:0]       pc    [NUM_WARPS];

  // Scheduler bookkeeping
  logic [UUID_WIDTH-1:0] uuid_cnt;
  logic [NW_WIDTH-1:0]   rr_ptr;

  // Selection results
  logic [NUM_WARPS-1:0]  eligible;
  logic                  found;
  logic [NW_WIDTH-1:0]   sel;
  logic                  load;
  logic                  do_issue;

  // A warp is eligible when active, not stalled, and not being rewritten by ctl/spawn this cycle
  always_comb begin
    eligible = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = active[w] & ~stalled[w]
                  & ~(ctl_valid && (ctl_wid == NW_WIDTH'(w)))
                  & ~(spawn_valid & spawn_mask[w]);
    end
  end

  // Round-robin scan starting one past the last loaded warp, wrapping modulo NUM_WARPS
  always_comb begin
    logic [NW_WIDTH-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = rr_ptr + NW_WIDTH'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign load     = ~sched_valid | sched_ready;
  assign do_issue = load & found;

  // Per-warp state update: spawn beats ctl, ctl beats unlock; the issued warp is never a ctl/spawn target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        stalled[w] <= 1'b0;
        if (w == 0) begin
          active[w] <= 1'b1;
          tmask[w]  <= '1;
          pc[w]     <= STARTUP_ADDR;
        end else begin
          active[w] <= 1'b0;
          tmask[w]  <= '0;
          pc[w]     <= '0;
        end
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (spawn_valid && spawn_mask[w]) begin
          active[w]  <= 1'b1;
          stalled[w] <= 1'b0;
          tmask[w]   <= '1;
          pc[w]      <= spawn_pc;
        end else if (ctl_valid && (ctl_wid == NW_WIDTH'(w))) begin
          pc[w]      <= ctl_pc;
          tmask[w]   <= ctl_tmask;
          stalled[w] <= 1'b0;
          if (ctl_tmask == '0) begin
            active[w] <= 1'b0;
          end
        end else if (do_issue && (sel == NW_WIDTH'(w))) begin
          stalled[w] <= 1'b1;
          pc[w]      <= pc[w] + XLEN'(4);
        end else if (unlock_valid && (unlock_wid == NW_WIDTH'(w))
                     && active[w] && stalled[w]) begin
          stalled[w] <= 1'b0;
        end
      end
    end
  end

  // Output slot, uuid counter and RR pointer advance only when a warp is loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sched_valid <= 1'b0;
      sched_uuid  <= '0;
      sched_wid   <= '0;
      sched_tmask <= '0;
      sched_pc    <= '0;
      uuid_cnt    <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (found) begin
        sched_valid <= 1'b1;
        sched_uuid  <= uuid_cnt;
        sched_wid   <= sel;
        sched_tmask <= tmask[sel];
        sched_pc    <= pc[sel];
        uuid_cnt    <= uuid_cnt + UUID_WIDTH'(1);
        rr_ptr      <= sel;
      end else begin
        sched_valid <= 1'b0;
      end
    end
  end

  assign busy = (|active) | sched_valid;

`ifdef VX_SCHED_PERF_EN
  logic [63:0] idles_q;
  logic [63:0] stalls_q;
  logic        idle_cycle;
  logic        stall_cycle;

  assign idle_cycle  = (|active) & ~sched_valid & ~(|eligible);
  assign stall_cycle = sched_valid & ~sched_ready;

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idles_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (idle_cycle && (idles_q != '1)) begin
        idles_q <= idles_q + 64'd1;
      end
      if (stall_cycle && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 64'd1;
      end
    end
  end

  assign perf_idles  = idles_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_idles  = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_warp_rr_sched.sv
// Directed bench for vx_warp_rr_sched with an expected-issue scoreboard.
module tb_vx_warp_rr_sched;

  localparam int NUM_WARPS  = 4;
  localparam int THREAD_CNT = 4;
  localparam int XLEN       = 32;
  localparam int UUID_WIDTH = 44;
  localparam int NW_WIDTH   = 2;

`ifdef VX_SCHED_PERF_EN
  localparam logic [63:0] EXP_STALLS = 64'd5;
`else
  localparam logic [63:0] EXP_STALLS = 64'd0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  spawn_valid;
  logic [NUM_WARPS-1:0]  spawn_mask;
  logic [XLEN-1:0]       spawn_pc;
  logic                  unlock_valid;
  logic [NW_WIDTH-1:0]   unlock_wid;
  logic                  ctl_valid;
  logic [NW_WIDTH-1:0]   ctl_wid;
  logic [THREAD_CNT-1:0] ctl_tmask;
  logic [XLEN-1:0]       ctl_pc;
  logic                  sched_valid;
  logic [UUID_WIDTH-1:0] sched_uuid;
  logic [NW_WIDTH-1:0]   sched_wid;
  logic [THREAD_CNT-1:0] sched_tmask;
  logic [XLEN-1:0]       sched_pc;
  logic                  sched_ready;
  logic                  busy;
  logic [63:0]           perf_idles;
  logic [63:0]           perf_stalls;

  vx_warp_rr_sched #(
    .NUM_WARPS   (NUM_WARPS),
    .THREAD_CNT  (THREAD_CNT),
    .XLEN        (XLEN),
    .UUID_WIDTH  (UUID_WIDTH),
    .STARTUP_ADDR(32'h80000000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spawn_valid (spawn_valid),
    .spawn_mask  (spawn_mask),
    .spawn_pc    (spawn_pc),
    .unlock_valid(unlock_valid),
    .unlock_wid  (unlock_wid),
    .ctl_valid   (ctl_valid),
    .ctl_wid     (ctl_wid),
    .ctl_tmask   (ctl_tmask),
    .ctl_pc      (ctl_pc),
    .sched_valid (sched_valid),
    .sched_uuid  (sched_uuid),
    .sched_wid   (sched_wid),
    .sched_tmask (sched_tmask),
    .sched_pc    (sched_pc),
    .sched_ready (sched_ready),
    .busy        (busy),
    .perf_idles  (perf_idles),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [THREAD_CNT-1:0] tmask;
    logic [XLEN-1:0]       pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fails   = 0;
  bit   auto_unlock = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int uuid, input int wid, input int tm, input logic [31:0] p);
    exp_t e;
    e.uuid  = UUID_WIDTH'(uuid);
    e.wid   = NW_WIDTH'(wid);
    e.tmask = THREAD_CNT'(tm);
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, score any newly presented slot
  task automatic tick();
    logic holding;
    exp_t e;
    holding = sched_valid && !sched_ready;
    @(posedge clk);
    #1;
    if (sched_valid && !holding) begin
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fails++;
        $error("FAIL unexpected_issue: observed wid %0d uuid %0h, expected no issue", sched_wid, sched_uuid);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_uuid",  64'(sched_uuid),  64'(e.uuid));
        chk("issue_wid",   64'(sched_wid),   64'(e.wid));
        chk("issue_tmask", 64'(sched_tmask), 64'(e.tmask));
        chk("issue_pc",    64'(sched_pc),    64'(e.pc));
      end
      if (auto_unlock) begin
        unlock_valid = 1'b1;
        unlock_wid   = sched_wid;
      end
    end else if (auto_unlock) begin
      unlock_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    spawn_valid  = 1'b0;
    spawn_mask   = '0;
    spawn_pc     = '0;
    unlock_valid = 1'b0;
    unlock_wid   = '0;
    ctl_valid    = 1'b0;
    ctl_wid      = '0;
    ctl_tmask    = '0;
    ctl_pc       = '0;
    sched_ready  = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 64'(sched_valid), 64'd0);
    chk("rst_uuid",  64'(sched_uuid),  64'd0);
    chk("rst_wid",   64'(sched_wid),   64'd0);
    chk("rst_tmask", 64'(sched_tmask), 64'd0);
    chk("rst_pc",    64'(sched_pc),    64'd0);
    chk("rst_busy",  64'(busy),        64'd1);
    chk("rst_idles", perf_idles,       64'd0);
    chk("rst_stalls", perf_stalls,     64'd0);

    // First issue after release: warp 0 at the startup address, then stalled
    reset_n = 1'b1;
    push(0, 0, 4'hf, 32'h80000000);
    tick();
    chk("first_issue_seen", 64'(exp_q.size()), 64'd0);
    tick();
    chk("w0_stalled_empty", 64'(sched_valid), 64'd0);
    chk("w0_stalled_busy",  64'(busy),        64'd1);
    tick();
    chk("w0_still_empty",   64'(sched_valid), 64'd0);

    // Spawn warps 1..3 and unlock each issue one cycle later: order 1,2,3,0,...
    spawn_valid  = 1'b1;
    spawn_mask   = 4'b1110;
    spawn_pc     = 32'h1000;
    unlock_valid = 1'b1;
    unlock_wid   = 2'd0;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = (k + 1) % 4;
      if (w == 0) push(1 + k, 0, 4'hf, 32'h80000004 + 32'(4 * (k / 4)));
      else        push(1 + k, w, 4'hf, 32'h1000 + 32'(4 * (k / 4)));
    end
    tick();
    spawn_valid  = 1'b0;
    unlock_valid = 1'b0;
    auto_unlock  = 1'b1;
    wait_drain(20);

    // Backpressure: slot holds uuid 8 / warp 0 for 5 cycles
    auto_unlock = 1'b0;
    sched_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      unlock_valid = 1'b0;
      chk("hold_valid", 64'(sched_valid), 64'd1);
      chk("hold_uuid",  64'(sched_uuid),  64'd8);
      chk("hold_wid",   64'(sched_wid),   64'd0);
      chk("hold_tmask", 64'(sched_tmask), 64'hf);
      chk("hold_pc",    64'(sched_pc),    64'h80000008);
    end
    chk("perf_stalls", perf_stalls, EXP_STALLS);

    // Release without unlocks: every warp issues once and then all are stalled
    push(9,  1, 4'hf, 32'h1008);
    push(10, 2, 4'hf, 32'h1008);
    push(11, 3, 4'hf, 32'h1008);
    push(12, 0, 4'hf, 32'h8000000c);
    sched_ready = 1'b1;
    wait_drain(10);
    tick();
    chk("all_stalled_empty", 64'(sched_valid), 64'd0);

    // Control resolution on stalled warp 2 redirects PC and tmask
    ctl_valid = 1'b1;
    ctl_wid   = 2'd2;
    ctl_tmask = 4'b0011;
    ctl_pc    = 32'h2000;
    push(13, 2, 4'b0011, 32'h2000);
    tick();
    ctl_valid = 1'b0;
    chk("ctl_cycle_empty", 64'(sched_valid), 64'd0);
    wait_drain(5);

    // Terminate warps 1..3, leaving warp 0 as the only active warp
    for (int w = 1; w < 4; w++) begin
      ctl_valid = 1'b1;
      ctl_wid   = NW_WIDTH'(w);
      ctl_tmask = '0;
      ctl_pc    = 32'h0;
      tick();
    end
    ctl_valid    = 1'b0;
    unlock_valid = 1'b1;
    unlock_wid   = 2'd0;
    push(14, 0, 4'hf, 32'h80000010);
    tick();
    unlock_valid = 1'b0;
    wait_drain(5);

    // Terminate warp 0 while its slot is still pending
    sched_ready = 1'b0;
    ctl_valid   = 1'b1;
    ctl_wid     = 2'd0;
    ctl_tmask   = '0;
    ctl_pc      = 32'h4000;
    tick();
    ctl_valid = 1'b0;
    chk("term_slot_valid", 64'(sched_valid), 64'd1);
    chk("term_busy_slot",  64'(busy),        64'd1);
    sched_ready = 1'b1;
    tick();
    chk("term_drained",    64'(sched_valid), 64'd0);
    chk("term_busy_low",   64'(busy),        64'd0);
    unlock_valid = 1'b1;
    unlock_wid   = 2'd0;
    tick();
    unlock_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("term_no_reissue", 64'(sched_valid), 64'd0);
      chk("term_idle_busy",  64'(busy),        64'd0);
    end

    // Spawn all warps, then assert reset mid-stream with a valid slot
    spawn_valid = 1'b1;
    spawn_mask  = 4'b1111;
    spawn_pc    = 32'h3000;
    push(15, 1, 4'hf, 32'h3000);
    push(16, 2, 4'hf, 32'h3000);
    tick();
    spawn_valid = 1'b0;
    wait_drain(5);
    chk("pre_reset_valid", 64'(sched_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(sched_valid), 64'd0);
    chk("async_rst_uuid",  64'(sched_uuid),  64'd0);
    chk("async_rst_pc",    64'(sched_pc),    64'd0);
    chk("async_rst_busy",  64'(busy),        64'd1);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    push(0, 0, 4'hf, 32'h80000000);
    wait_drain(5);
    tick();
    chk("restart_w0_stalled", 64'(sched_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
